// File: rtl/vscale_dmem_responder.sv
// vscale_dmem_responder: data-memory target with wait states, byte-lane stores and bad-access flagging (clk, reset, dmem_* request in, dmem_rdata/dmem_wait/dmem_badmem_e out)
module vscale_dmem_responder #(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic [31:0] dmem_rdata,
  output logic        dmem_wait,
  output logic        dmem_badmem_e
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, DATA} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [31:0] mem [DEPTH];
  logic wen_q, err_q, done, accept;
  logic [1:0] sz_q, ofs_q;
  logic [IW-1:0] idx_q;
  logic [32:0] off;
  logic range_err, size_err, mis_err;
  logic [3:0] mask;
  logic [31:0] lane;
  assign off = {1'b0, dmem_addr} - {1'b0, BASE_ADDR};
  assign range_err = off[32] || (off[31:0] >= (32'(DEPTH) << 2));
  assign size_err = dmem_size[1:0] == 2'd3 || (dmem_size[2] && dmem_size[1]);
  assign mis_err = (dmem_size[1:0] == 2'd1 && dmem_addr[0]) || (dmem_size[1:0] == 2'd2 && dmem_addr[1:0] != 2'd0);
  assign mask = sz_q == 2'd0 ? 4'b0001 << ofs_q : sz_q == 2'd1 ? 4'b0011 << ofs_q : 4'b1111;
  assign lane = sz_q == 2'd0 ? {4{dmem_wdata_delayed[7:0]}} : sz_q == 2'd1 ? {2{dmem_wdata_delayed[15:0]}} : dmem_wdata_delayed;
  always_comb begin
    dmem_wait = state == DATA && cnt != 4'd0;
    done = state == DATA && cnt == 4'd0;
    accept = dmem_en && !dmem_wait;
    state_d = (accept || dmem_wait) ? DATA : IDLE;
    cnt_d = accept ? 4'(WAIT_CYCLES) : dmem_wait ? cnt - 4'd1 : cnt;
    dmem_rdata = (done && !wen_q && !err_q) ? mem[idx_q] : 32'd0;
    dmem_badmem_e = done && err_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      wen_q <= 1'b0;
      err_q <= 1'b0;
      sz_q <= 2'd0;
      ofs_q <= 2'd0;
      idx_q <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      if (accept) begin
        wen_q <= dmem_wen;
        err_q <= range_err || size_err || mis_err;
        sz_q <= dmem_size[1:0];
        ofs_q <= dmem_addr[1:0];
        idx_q <= off[IW+1:2];
      end
    end
  end
  // A load accepted on this edge reads in the next cycle, so it sees the committed store.
  always_ff @(posedge clk) begin
    if (!reset && done && wen_q && !err_q)
      for (int i = 0; i < 4; i++)
        if (mask[i]) mem[idx_q][8*i +: 8] <= lane[8*i +: 8];
  end
endmodule

// File: doc/vscale_dmem_responder.md
Name: vscale_dmem_responder

Overview:
- Target-side model of the core's data-memory port: accepts pipelined address-phase requests and completes them one data phase later.
- Holds a word-addressed backing array and inserts a programmable number of wait states.
- Shifts store data into byte lanes under a byte mask and flags misaligned, out-of-range and illegal-size accesses via dmem_badmem_e.
- Sits opposite vscale_core's dmem_* pins in the test harness and in small FPGA builds.

Parameters:
- DEPTH, 1024: backing array size in 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.
- WAIT_CYCLES, 0: dmem_wait cycles inserted per data phase; range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dmem_en  in  1  address-phase request valid.
- dmem_wen  in  1  1 = store, 0 = load.
- dmem_size  in  3  access type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; 3, 6 and 7 are illegal.
- dmem_addr  in  32  byte address, address phase.
- dmem_wdata_delayed  in  32  store data, valid in the data phase; LSB-justified.
- dmem_rdata  out  32  raw aligned word at addr[31:2], valid in the completing data-phase cycle.
- dmem_wait  out  1  1 = data phase not complete; the core holds its pipeline.
- dmem_badmem_e  out  1  error strobe in the completing data-phase cycle.

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to IDLE, wait counter to 0.
  - dmem_wait = 0, dmem_badmem_e = 0, dmem_rdata = 0.
  - Any pending write is dropped; array contents are not cleared.
  - Reset mid-data-phase aborts the access.
- FSM states: IDLE, DATA.
- Acceptance:
  - A request is accepted on an edge where dmem_en = 1 and dmem_wait = 0.
  - On acceptance, latch addr, wen, size and the error flags; load the counter with WAIT_CYCLES; go to DATA.
- DATA state:
  - While counter != 0: dmem_wait = 1, counter decrements each cycle, dmem_rdata = 0, dmem_badmem_e = 0.
  - Address-phase inputs presented while dmem_wait = 1 are ignored (the core holds them stable).
- Completion cycle (DATA with counter = 0):
  - dmem_wait = 0.
  - dmem_rdata = mem[idx] for loads, 0 for stores or on error.
  - dmem_badmem_e = latched error.
  - A store with no error commits at the end of this cycle.
  - On the same edge: if dmem_en = 1, accept the next request and stay in DATA (back-to-back, no bubble); otherwise go to IDLE.
- IDLE: dmem_wait = 0, dmem_rdata = 0, dmem_badmem_e = 0.
- Latency:
  - WAIT_CYCLES = 0: result one cycle after acceptance, full throughput of one access per cycle.
  - WAIT_CYCLES = N: result in cycle N+1 after acceptance.
- Error detection, evaluated at acceptance:
  - Misaligned: halfword with addr[0] = 1, or word with addr[1:0] != 0.
  - Out of range: addr < BASE_ADDR, or (addr − BASE_ADDR) >> 2 >= DEPTH.
  - Illegal size code.
- On error: the store is suppressed, dmem_rdata = 0, and the wait states are still inserted.
- Index: idx = (addr − BASE_ADDR)[31:2], truncated to clog2(DEPTH) bits after the range check.
- Store lane steering, with o = addr[1:0]:
  - Byte: mask = 4'b0001 << o; wdata[7:0] is replicated to all lanes.
  - Half: mask = 4'b0011 << o; wdata[15:0] is replicated to both halves.
  - Word: mask = 4'b1111.
  - Unmasked bytes are unchanged.
- Read-after-write: a load accepted on the same edge a store commits to the same word returns the new data. No forwarding is needed because the read happens in the later cycle.
- Signed vs unsigned and sub-word extraction are the core's job; the responder always returns the full word.

Test Plan:
1. Reset, WAIT_CYCLES = 0, BASE_ADDR = 0.
   - SW 0xDEADBEEF to 0x10, then LW 0x10 back-to-back → rdata = 0xDEADBEEF in the cycle after the LW is accepted; dmem_wait stays 0 throughout.
2. Word 0x10 = 0xDEADBEEF, then SB 0x000000A5 to 0x11 and SH 0x00001234 to 0x12; LW 0x10 → 0x1234A5EF.
3. Error cases:
   - LH at 0x13 → badmem_e = 1, rdata = 0.
   - SW at 4*DEPTH → badmem_e = 1, and a following LW of word 0 is unchanged.
   - size = 3 → badmem_e = 1.
4. WAIT_CYCLES = 3: LW accepted at cycle t → dmem_wait = 1 in t+1..t+3, data and wait = 0 at t+4.
   - A second request held on dmem_en from t+1 is accepted only at the t+4 edge.
5. Reset asserted in the second wait cycle of an SW to 0x20 (old value 0x11111111) → dmem_wait = 0 on the next cycle; a later LW 0x20 returns 0x11111111.
6. 64 back-to-back alternating SW/LW to random in-range aligned addresses at WAIT_CYCLES = 0 and 2 → every load matches the scoreboard; no spurious badmem_e.
